qmem_arbiter: RTL and testbench
===============================

// Module: qmem_arbiter
// PURPOSE
//  Shares the single-port Q-table RAM between N_REQ requesters: 0 = actor action-select reads,
//  1 = learner read-modify-write updates, 2 = target-table sync bursts.
//  Round-robin arbitration with per-requester lock for atomic bursts and a lock timeout.
//  Read data returns one cycle after grant. Sits between the DQN datapath units and the Q-table RAM.
// PARAMETERS
//  N_REQ     3    number of requesters (2..8)
//  ADDR_W    8    Q-table address width (state x action index)
//  DATA_W    16   Q-value width
//  LOCK_MAX  15   max consecutive cycles one owner may hold the lock
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous reset, active-low
//  req        in   N_REQ           request per requester
//  we         in   N_REQ           1 = write, 0 = read, per requester
//  lock       in   N_REQ           hold grant after this transfer
//  addr       in   N_REQ*ADDR_W    address, requester i at [i*ADDR_W +: ADDR_W]
//  wdata      in   N_REQ*DATA_W    write data, requester i at [i*DATA_W +: DATA_W]
//  gnt        out  N_REQ           one-hot grant; transfer accepted when req[i] & gnt[i]
//  rvalid     out  N_REQ           read data valid for requester i
//  rdata      out  DATA_W          read data, shared by all requesters
//  mem_en     out  1               RAM enable
//  mem_we     out  1               RAM write enable
//  mem_addr   out  ADDR_W          RAM address
//  mem_wdata  out  DATA_W          RAM write data
//  mem_rdata  in   DATA_W          RAM read data, 1-cycle latency
//  busy       out  1               lock held (state OWN)
//  lock_err   out  1               one-cycle pulse on forced lock release
// BEHAVIOUR
//  - Reset (rst = 0, async): gnt = 0, rvalid = 0, lock_err = 0, state = IDLE, rr_ptr = N_REQ-1,
//    lock_cnt = 0. Outputs hold these values until the first clk edge after rst = 1.
//  - gnt is combinational from req, state, rr_ptr. At most one bit is set; gnt is 0 when req = 0.
//  - IDLE arbitration: search from index rr_ptr+1 upward, wrapping at N_REQ. The first requester
//    with req = 1 wins. From reset, requester 0 wins first.
//  - mem_en = |(req & gnt). mem_we, mem_addr and mem_wdata come from the winner in the same cycle.
//    When mem_en = 0, mem_we = 0.
//  - Read accepted in cycle t: rvalid[i] = 1 in cycle t+1 only, and rdata = mem_rdata.
//    A write never raises rvalid. Back-to-back reads give rvalid in consecutive cycles.
//  - rr_ptr <= winner index on every accepted transfer.
//  - Transition IDLE -> OWN: accepted transfer with lock[w] = 1. Then owner <= w and lock_cnt <= 1.
//  - In OWN, only the owner can be granted; every other req waits with gnt = 0.
//  - Transition OWN -> IDLE on any of:
//    (a) owner's accepted transfer with lock = 0; that transfer completes normally.
//    (b) req[owner] = 0 for one cycle.
//    (c) lock_cnt reaches LOCK_MAX. lock_cnt increments each OWN cycle; on reaching LOCK_MAX,
//        lock_err pulses 1 cycle and the next cycle arbitrates from owner+1 (IDLE).
//  - busy = (state == OWN). A transfer of a requester whose lock falls while other requests are
//    pending is followed by round-robin arbitration starting at owner+1.
//  - Read-after-write to the same address in consecutive cycles returns the new value;
//    ordering is preserved by the single RAM port.
//  - Reset asserted mid-burst: lock, pending rvalid and pointer are all cleared; no rvalid is
//    issued for a read accepted in the reset cycle.
// TESTING
//  1. Reset, then req = 3'b111, lock = 0, all reads: gnt sequence 001, 010, 100, 001;
//     rvalid follows gnt delayed by one cycle; mem_addr tracks the winner each cycle.
//  2. Learner RMW: req[1] read addr 8'h2A with lock = 1, then write addr 8'h2A with lock = 0,
//     while req[0] is held high: gnt = 010, 010, then 001; busy = 1 for exactly 1 cycle;
//     the actor's read of 8'h2A returns the written value.
//  3. Sync burst: req[2] locked for 20 cycles with LOCK_MAX = 15: lock_err pulses at the 15th
//     OWN cycle; requester 0 is granted the next cycle if requesting.
//  4. Owner drops req mid-lock: busy falls in the following cycle and waiting requester 1 is granted.
//  5. rst = 0 asserted asynchronously mid-cycle during a locked read: gnt, rvalid and busy go to 0
//     immediately; after release, requester 0 wins first.
//  6. Single requester 2 issuing 4 back-to-back reads: gnt[2] stays 1; rvalid[2] is high for 4
//     consecutive cycles starting one cycle later.

Source files
------------

// File: rtl/qmem_arbiter.sv
// Single-port Q-table RAM arbiter: round-robin between requesters, with an optional
// per-owner lock for atomic bursts that is forcibly released after LOCK_MAX cycles.
module qmem_arbiter #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0]          we_i,
    input  logic [N_REQ-1:0]          lock_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    input  logic [N_REQ*DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic                      busy_o,
    output logic                      lock_err_o
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic              armed_q;

    logic              win_vld;
    logic [IdxW-1:0]   win_idx;
    logic [IdxW-1:0]   cand;
    logic              force_rel;

    // Outputs stay quiet until the first clock edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rr_ptr_q   <= IdxW'(N_REQ - 1);
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            armed_q    <= 1'b1;
        end
    end

    // Winner selection: the lock owner only, or a round-robin search starting after rr_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        if (state_q == StOwn) begin
            win_vld = req_i[owner_q];
            win_idx = owner_q;
        end else begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = IdxW'((32'(rr_ptr_q) + k) % N_REQ);
                if (!win_vld && req_i[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
        win_vld = win_vld & armed_q;
    end

    assign force_rel = (state_q == StOwn) && win_vld && lock_i[owner_q] &&
                       (lock_cnt_q == CntW'(LOCK_MAX));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rvalid_d   = '0;
        if (win_vld) begin
            rr_ptr_d = win_idx;
            if (!we_i[win_idx]) rvalid_d = gnt_o;
        end
        unique case (state_q)
            StIdle: begin
                if (win_vld && lock_i[win_idx]) begin
                    state_d    = StOwn;
                    owner_d    = win_idx;
                    lock_cnt_d = CntW'(1);
                end
            end
            StOwn: begin
                if (!win_vld || !lock_i[owner_q] || force_rel) begin
                    state_d    = StIdle;
                    lock_cnt_d = '0;
                    rr_ptr_d   = owner_q;
                end else begin
                    lock_cnt_d = lock_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_o       = win_vld ? (N_REQ'(1) << win_idx) : '0;
        mem_en_o    = win_vld;
        mem_we_o    = win_vld & we_i[win_idx];
        mem_addr_o  = addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
        mem_wdata_o = wdata_i[32'(win_idx)*DATA_W +: DATA_W];
        rvalid_o    = rvalid_q;
        rdata_o     = mem_rdata_i;
        busy_o      = (state_q == StOwn);
        lock_err_o  = force_rel;
    end

endmodule

// File: tb/tb_qmem_arbiter.sv
// Bench for qmem_arbiter: directed scenarios plus a randomized run, all checked against
// a transaction-level model of holder / pointer / Q-table contents kept in the bench.
module tb_qmem_arbiter;

    localparam int LOCK_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [2:0]  req = '0, we = '0, lock = '0;
    logic [23:0] addr = '0;
    logic [47:0] wdata = '0;
    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, busy, lock_err;
    logic [7:0]  mem_addr;

    logic [15:0] ram [256];
    logic [15:0] ref_mem [256];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: holder (-1 = none), cycles held, last winner, armed flag.
    int          m_hold, m_held, m_last;
    bit          m_live;
    logic [2:0]  m_rv;
    logic [15:0] m_rd;
    int          e_w;
    logic [2:0]  e_gnt;
    logic        e_busy, e_err;

    qmem_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy),
        .lock_err_o(lock_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    function automatic void model_reset();
        m_hold = -1; m_held = 0; m_last = 2; m_live = 0; m_rv = '0; m_rd = '0;
    endfunction

    function automatic void model_eval();
        e_w = -1;
        if (m_live) begin
            if (m_hold >= 0) begin
                if (req[m_hold]) e_w = m_hold;
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    int i;
                    i = (m_last + k) % 3;
                    if (e_w < 0 && req[i]) e_w = i;
                end
            end
        end
        e_gnt  = (e_w >= 0) ? 3'(1 << e_w) : 3'b000;
        e_busy = (m_hold >= 0);
        e_err  = (m_hold >= 0) && (e_w >= 0) && lock[m_hold] && (m_held == LOCK_MAX);
    endfunction

    function automatic void model_step();
        logic [7:0] a;
        model_eval();
        m_rv = '0;
        if (e_w >= 0) begin
            a = addr[e_w*8 +: 8];
            if (we[e_w]) ref_mem[a] = wdata[e_w*16 +: 16];
            else begin
                m_rv = e_gnt;
                m_rd = ref_mem[a];
            end
            m_last = e_w;
        end
        if (m_hold < 0) begin
            if (e_w >= 0 && lock[e_w]) begin
                m_hold = e_w;
                m_held = 1;
            end
        end else if (e_w < 0 || !lock[m_hold] || m_held == LOCK_MAX) begin
            m_hold = -1;
        end else begin
            m_held++;
        end
        m_live = 1;
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rq(input int i, input bit r, input bit w, input bit l,
                          input logic [7:0] a, input logic [15:0] d);
        req[i] = r; we[i] = w; lock[i] = l;
        addr[i*8 +: 8] = a;
        wdata[i*16 +: 16] = d;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        req = '0; we = '0; lock = '0;
        model_reset();
        @(posedge clk);
        #5;
        rst_ni = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req = 3'b111; we = '0; lock = '0;
        #3;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt got %b want 000", gnt); end
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL reset_rvalid got %b want 000", rvalid); end
        n_cmp++; if ({busy, lock_err, mem_en} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags busy/err/en got %b want 000", {busy, lock_err, mem_en});
        end
        @(posedge clk);
        #5;
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_release_gnt got %b want 000", gnt); end
        model_reset();
        cyc();
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [4];
        logic [2:0] prev;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
        prev = 3'b000;
        apply_reset();
        for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 16'h0);
        for (int c = 0; c < 4; c++) begin
            #4;
            n_cmp++; if (gnt !== seq[c]) begin n_err++; $display("FAIL rr_gnt c%0d got %b want %b", c, gnt, seq[c]); end
            n_cmp++; if (mem_addr !== 8'(8'h10 + c % 3)) begin
                n_err++; $display("FAIL rr_addr c%0d got %h want %h", c, mem_addr, 8'(8'h10 + c % 3));
            end
            n_cmp++; if (rvalid !== prev) begin n_err++; $display("FAIL rr_rvalid c%0d got %b want %b", c, rvalid, prev); end
            prev = seq[c];
            cyc();
        end
    endtask

    task automatic test_rmw();
        int busy_cycles;
        busy_cycles = 0;
        apply_reset();
        set_rq(0, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0);
        #4; cyc();
        set_rq(0, 1'b1, 1'b0, 1'b0, 8'h2A, 16'h0);
        set_rq(1, 1'b1, 1'b0, 1'b1, 8'h2A, 16'h0);
        #4; model_eval();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rmw_gnt_rd got %b want 010", gnt); end
        if (busy) busy_cycles++;
        cyc();
        set_rq(1, 1'b1, 1'b1, 1'b0, 8'h2A, 16'hBEEF);
        #4;
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rmw_gnt_wr got %b want 010", gnt); end
        n_cmp++; if (rvalid !== 3'b010 || rdata !== m_rd) begin
            n_err++; $display("FAIL rmw_learner_rd got %b/%h want 010/%h", rvalid, rdata, m_rd);
        end
        if (busy) busy_cycles++;
        cyc();
        set_rq(1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
        #4;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rmw_gnt_actor got %b want 001", gnt); end
        if (busy) busy_cycles++;
        cyc();
        req = '0;
        #4;
        n_cmp++; if (busy_cycles !== 1) begin n_err++; $display("FAIL rmw_busy_len got %0d want 1", busy_cycles); end
        n_cmp++; if (rvalid !== 3'b001 || rdata !== 16'hBEEF) begin
            n_err++; $display("FAIL rmw_raw got %b/%h want 001/beef", rvalid, rdata);
        end
        cyc();
    endtask

    task automatic test_sync_burst();
        apply_reset();
        set_rq(2, 1'b1, 1'b0, 1'b1, 8'h40, 16'h0);
        #4;
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL burst_entry got %b want 100", gnt); end
        cyc();
        set_rq(0, 1'b1, 1'b0, 1'b0, 8'h01, 16'h0);
        for (int k = 1; k <= 15; k++) begin
            addr[16 +: 8] = 8'(8'h40 + k);
            #4;
            n_cmp++; if (gnt !== 3'b100 || busy !== 1'b1) begin
                n_err++; $display("FAIL burst_hold k%0d got gnt %b busy %b want 100/1", k, gnt, busy);
            end
            n_cmp++; if (lock_err !== (k == 15)) begin
                n_err++; $display("FAIL burst_err k%0d got %b want %b", k, lock_err, k == 15);
            end
            cyc();
        end
        #4;
        n_cmp++; if (gnt !== 3'b001 || busy !== 1'b0 || lock_err !== 1'b0) begin
            n_err++; $display("FAIL burst_after got gnt %b busy %b err %b want 001/0/0", gnt, busy, lock_err);
        end
        cyc();
        for (int k = 0; k < 4; k++) begin
            #4; model_eval();
            n_cmp++; if (gnt !== e_gnt) begin n_err++; $display("FAIL burst_tail k%0d got %b want %b", k, gnt, e_gnt); end
            cyc();
        end
    endtask

    task automatic test_owner_drop();
        apply_reset();
        set_rq(2, 1'b1, 1'b0, 1'b1, 8'h60, 16'h0);
        #4; cyc();
        set_rq(1, 1'b1, 1'b0, 1'b0, 8'h61, 16'h0);
        #4;
        n_cmp++; if (gnt !== 3'b100 || busy !== 1'b1) begin
            n_err++; $display("FAIL drop_own got gnt %b busy %b want 100/1", gnt, busy);
        end
        cyc();
        req[2] = 1'b0;
        #4;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL drop_wait got %b want 000", gnt); end
        cyc();
        #4;
        n_cmp++; if (busy !== 1'b0 || gnt !== 3'b010) begin
            n_err++; $display("FAIL drop_next got gnt %b busy %b want 010/0", gnt, busy);
        end
        cyc();
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_rq(2, 1'b1, 1'b0, 1'b1, 8'h70, 16'h0);
        #4; cyc();
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (gnt !== 3'b000 || rvalid !== 3'b000 || busy !== 1'b0) begin
            n_err++; $display("FAIL arst_now got gnt %b rv %b busy %b want 000/000/0", gnt, rvalid, busy);
        end
        @(posedge clk);
        #1;
        n_cmp++; if (rvalid !== 3'b000) begin n_err++; $display("FAIL arst_rvalid got %b want 000", rvalid); end
        #4;
        rst_ni = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) set_rq(i, 1'b1, 1'b0, 1'b0, 8'(i), 16'h0);
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL arst_quiet got %b want 000", gnt); end
        cyc();
        #4;
        n_cmp++; if (gnt !== 3'b001 || rvalid !== 3'b000) begin
            n_err++; $display("FAIL arst_first got gnt %b rv %b want 001/000", gnt, rvalid);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [2:0] want_g, want_rv;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) set_rq(2, 1'b1, 1'b0, 1'b0, 8'(8'h80 + c), 16'h0);
            else       req = '0;
            #4;
            want_g  = (c < 4) ? 3'b100 : 3'b000;
            want_rv = (c >= 1 && c <= 4) ? 3'b100 : 3'b000;
            n_cmp++; if (gnt !== want_g) begin n_err++; $display("FAIL b2b_gnt c%0d got %b want %b", c, gnt, want_g); end
            n_cmp++; if (rvalid !== want_rv) begin
                n_err++; $display("FAIL b2b_rvalid c%0d got %b want %b", c, rvalid, want_rv);
            end
            if (want_rv != 3'b000) begin
                n_cmp++; if (rdata !== m_rd) begin n_err++; $display("FAIL b2b_rdata c%0d got %h want %h", c, rdata, m_rd); end
            end
            cyc();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++)
                set_rq(i, $urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                       8'($urandom_range(0, 7)), 16'($urandom));
            #4; model_eval();
            n_cmp++; if (gnt !== e_gnt || busy !== e_busy || lock_err !== e_err) begin
                n_err++; $display("FAIL rnd_ctl c%0d got gnt %b busy %b err %b want %b/%b/%b",
                                  c, gnt, busy, lock_err, e_gnt, e_busy, e_err);
            end
            n_cmp++; if (mem_en !== (e_w >= 0)) begin
                n_err++; $display("FAIL rnd_en c%0d got %b want %b", c, mem_en, e_w >= 0);
            end
            if (e_w >= 0) begin
                n_cmp++; if (mem_we !== we[e_w] || mem_addr !== addr[e_w*8 +: 8] ||
                             (we[e_w] && mem_wdata !== wdata[e_w*16 +: 16])) begin
                    n_err++; $display("FAIL rnd_mem c%0d got we %b a %h d %h", c, mem_we, mem_addr, mem_wdata);
                end
            end else begin
                n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rnd_we_idle c%0d got %b want 0", c, mem_we); end
            end
            n_cmp++; if (rvalid !== m_rv) begin n_err++; $display("FAIL rnd_rvalid c%0d got %b want %b", c, rvalid, m_rv); end
            if (m_rv != 3'b000) begin
                n_cmp++; if (rdata !== m_rd) begin n_err++; $display("FAIL rnd_rdata c%0d got %h want %h", c, rdata, m_rd); end
            end
            cyc();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'(i * 37 + 5);
            ref_mem[i] = 16'(i * 37 + 5);
        end
        model_reset();
        test_reset();
        test_round_robin();
        test_rmw();
        test_sync_burst();
        test_owner_drop();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
